imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried alongside each immediate.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry elastic stage with registered in_ready, 0 = single-entry stage with combinational in_ready.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discards all held entries.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1  upstream handshake.
REQ-008 SHALL have port instr  input  25  instruction bits [31:7].
REQ-009 SHALL have port immsrc  input  3  format select.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband, passed through unmodified.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1  downstream handshake.
REQ-012 SHALL have ports immext output XLEN, out_tag output TAG_W, illegal output 1.

Function
REQ-013 SHALL decode immsrc: 000 I {instr[31:20]}, 001 S {instr[31:25],instr[11:7]}, 010 B {instr[31],instr[7],instr[30:25],instr[11:8],0}, 011 J {instr[31],instr[19:12],instr[20],instr[30:21],0}, 100 U {instr[31:12],12'b0}; each sign-extended from its MSB to XLEN.
REQ-014 SHALL decode immsrc 101 as shift amount: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-015 SHALL, for immsrc 110/111, produce immext = 0 and illegal = 1; illegal = 0 for all other codes.
REQ-016 SHALL accept an input when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 SHALL have latency exactly 1 cycle: an entry accepted at edge N is presented with out_valid = 1 after edge N.
REQ-018 SHALL hold immext, out_tag, illegal stable while out_valid && !out_ready.
REQ-019 SHALL (SKID=1) keep a main and a skid register; in_ready = !skid_valid (registered); an accept while the main entry stalls loads skid; when main drains, skid moves to main on the same edge.
REQ-020 SHALL (SKID=0) set in_ready = !out_valid || out_ready.
REQ-021 SHALL preserve order; no entry dropped or duplicated except by flush/reset.
REQ-022 SHALL on flush clear all valid bits at the next edge; an input offered in the flush cycle is discarded; flush wins over simultaneous accept/transfer.
REQ-023 SHALL sustain one entry per cycle when out_ready is held high.

Reset
REQ-024 SHALL on reset clear main and skid valid bits; out_valid = 0, immext = 0, out_tag = 0, illegal = 0 after the reset edge.
REQ-025 SHALL drive in_ready = 1 in the cycle after reset deasserts; reset mid-stall drops held entries.

Structure
REQ-026 SHALL define immsrc encodings (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT) as an enum typedef in shared package riscv_pkg, with the XLEN default constant.
REQ-027 SHALL place the combinational decode in sub-module imm_decode (instr, immsrc -> immext, illegal), parametrised by XLEN; imm_gen_pipe instantiates it once at its input.
REQ-028 SHALL contain no latches; all state in clk-edge registers.

Verification
REQ-029 XLEN=32, I, instr=0xFFF00093>>7 -> immext 0xFFFFFFFF, illegal 0, one cycle later.
REQ-030 XLEN=32, U 0x123450B7 -> 0x12345000; J 0x0010006F -> 0x00000800; B 0x00000863 -> 0x00000010; S 0xFE20AE23 -> 0xFFFFFFFC.
REQ-031 XLEN=64, shamt 0x03F09093 -> immext 63; immsrc 110 -> immext 0, illegal 1.
REQ-032 SKID=1, back-to-back 3 inputs, out_ready low 2 cycles -> in_ready drops after 2 accepts, outputs emerge in order, no loss.
REQ-033 Flush with main+skid full and in_valid high -> next cycle out_valid 0, in_ready 1, flushed input never appears.
REQ-034 Reset asserted during stall -> out_valid 0, immext 0 after edge; streaming resumes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared immediate-format encodings and XLEN default
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_RSV6  = 3'b110,
    IMM_RSV7  = 3'b111
  } immsrc_e;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate extraction from instruction bits [31:7]
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [24:0]     instr,
  input  immsrc_e         immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  // instr[k] holds original instruction bit k+7
  always_comb begin
    immext  = '0;
    illegal = 1'b0;
    unique case (immsrc)
      IMM_I: immext = XLEN'($signed(instr[24:13]));
      IMM_S: immext = XLEN'($signed({instr[24:18], instr[4:0]}));
      IMM_B: immext = XLEN'($signed({instr[24], instr[0], instr[23:18], instr[4:1], 1'b0}));
      IMM_J: immext = XLEN'($signed({instr[24], instr[12:5], instr[13], instr[23:14], 1'b0}));
      IMM_U: immext = XLEN'($signed({instr[24:5], 12'b0}));
      IMM_SHAMT: begin
        if (XLEN == 64) immext = XLEN'(instr[18:13]);
        else            immext = XLEN'(instr[17:13]);
      end
      default: begin
        immext  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - one-cycle elastic pipeline stage around the immediate decoder
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (instr),
    .immsrc  (immsrc_e'(immsrc)),
    .immext  (dec_imm),
    .illegal (dec_ill)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;
  logic             in_fire, out_fire;

  // Without a skid register the stage can only accept when main empties this cycle
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !skid_valid_q;
    end else begin : g_noskid
      assign in_ready = !main_valid_q || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // skid is only ever occupied while in_ready is low, so no input competes with it
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_tag_d   = in_tag;
        main_ill_d   = dec_ill;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_tag_d   = in_tag;
      skid_ill_d   = dec_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid = main_valid_q;
  assign immext    = main_imm_q;
  assign out_tag   = main_tag_q;
  assign illegal   = main_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - bench: XLEN=32/SKID=1 and XLEN=64/SKID=0 against a queue model
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  immsrc;
  logic [31:0] in_tag;

  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .immext(imm32), .out_tag(tag32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID(0)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .immext(imm64), .out_tag(tag64), .illegal(ill64)
  );

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [31:0] tag;
    logic        ill;
  } ent_t;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  s;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  ent_t q32[$];
  ent_t q64[$];
  vec_t vt[8];
  logic [31:0] cur_w;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value rebuilt from the full 32-bit word with plain arithmetic
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, input int xlen);
    longint x, v;
    x = longint'({32'b0, w});
    v = 0;
    case (s)
      3'd0: begin v = x >> 20; if (w[31]) v -= 64'sd4096; end
      3'd1: begin v = ((x >> 25) << 5) | ((x >> 7) & 31); if (w[31]) v -= 64'sd4096; end
      3'd2: begin
        v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1);
        if (w[31]) v -= 64'sd8192;
      end
      3'd3: begin
        v = (((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1);
        if (w[31]) v -= 64'sd2097152;
      end
      3'd4: begin v = x & 64'hFFFF_F000; if (w[31]) v -= 64'sh1_0000_0000; end
      3'd5: v = (x >> 20) & ((xlen == 64) ? 63 : 31);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic set_in(input logic [31:0] w, input logic [2:0] s, input logic [31:0] t);
    cur_w  = w;
    instr  = w[31:7];
    immsrc = s;
    in_tag = t;
  endtask

  // One clock: check DUT against model, advance model, cross the edge
  task automatic cycle();
    ent_t e;
    logic acc32, acc64;
    #1;
    if (!reset) begin
      chk("in_ready32", rdy32, q32.size() < 2);
      chk("in_ready64", rdy64, (q64.size() == 0) || out_ready);
      chk("out_valid32", ov32, q32.size() > 0);
      chk("out_valid64", ov64, q64.size() > 0);
      if (q32.size() > 0) begin
        chk("immext32", imm32, q32[0].i32);
        chk("tag32", tag32, q32[0].tag);
        chk("illegal32", ill32, q32[0].ill);
      end
      if (q64.size() > 0) begin
        chk("immext64", imm64, q64[0].i64);
        chk("tag64", tag64, q64[0].tag);
        chk("illegal64", ill64, q64[0].ill);
      end
    end
    acc32 = in_valid && (q32.size() < 2);
    acc64 = in_valid && ((q64.size() == 0) || out_ready);
    e.i32 = ref_imm(cur_w, immsrc, 32);
    e.i64 = ref_imm(cur_w, immsrc, 64);
    e.tag = in_tag;
    e.ill = (immsrc >= 3'd6);
    if (reset || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (out_ready && q32.size() > 0) void'(q32.pop_front());
      if (out_ready && q64.size() > 0) void'(q64.pop_front());
      if (acc32) q32.push_back(e);
      if (acc64) q64.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{32'hFFF00093, 3'd0, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[1] = '{32'h123450B7, 3'd4, 64'h0000_0000_1234_5000, 64'h0000_0000_1234_5000, 1'b0};
    vt[2] = '{32'h0010006F, 3'd3, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0800, 1'b0};
    vt[3] = '{32'h00000863, 3'd2, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0010, 1'b0};
    vt[4] = '{32'hFE20AE23, 3'd1, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vt[5] = '{32'h03F09093, 3'd5, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_003F, 1'b0};
    vt[6] = '{32'hFFFFFFFF, 3'd6, 64'h0,                   64'h0,                   1'b1};
    vt[7] = '{32'h80000000, 3'd7, 64'h0,                   64'h0,                   1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(32'h0, 3'd0, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_out_valid32", ov32, 0);
    chk("rst_immext32", imm32, 0);
    chk("rst_tag32", tag32, 0);
    chk("rst_illegal32", ill32, 0);
    chk("rst_out_valid64", ov64, 0);
    chk("rst_immext64", imm64, 0);
    chk("rst_in_ready32", rdy32, 1);
    chk("rst_in_ready64", rdy64, 1);

    // Known-answer vectors, each visible exactly one edge after acceptance
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].w, vt[i].s, 32'hA000_0000 + i);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid32", i), ov32, 1);
      chk($sformatf("vec%0d_imm32", i), imm32, vt[i].e32);
      chk($sformatf("vec%0d_ill32", i), ill32, vt[i].ill);
      chk($sformatf("vec%0d_tag32", i), tag32, 32'hA000_0000 + i);
      chk($sformatf("vec%0d_imm64", i), imm64, vt[i].e64);
      chk($sformatf("vec%0d_ill64", i), ill64, vt[i].ill);
    end
    cycle();
    cycle();

    // Three back-to-back inputs into a stalled SKID=1 stage
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in($urandom, 3'($urandom_range(0, 5)), 32'hB000_0000 + i);
      cycle();
    end
    chk("stall_in_ready32", rdy32, 0);
    chk("stall_head_tag32", tag32, 32'hB000_0000);
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d_tag32", i), tag32, 32'hB000_0000 + i);
      if (i == 2) in_valid = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Flush with main+skid occupied and an input offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(32'h00100093, 3'd0, 32'hC000_0001);
    cycle();
    set_in(32'h00200093, 3'd0, 32'hC000_0002);
    cycle();
    set_in(32'h00300093, 3'd0, 32'hC000_0003);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid32", ov32, 0);
    chk("flush_in_ready32", rdy32, 1);
    chk("flush_out_valid64", ov64, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_reappear32", ov32, 0);
      cycle();
    end

    // Reset during a stall, then streaming resumes
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(32'hFFF00093, 3'd0, 32'hD000_0001);
    cycle();
    set_in(32'h123450B7, 3'd4, 32'hD000_0002);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    chk("rst2_out_valid32", ov32, 0);
    chk("rst2_immext32", imm32, 0);
    chk("rst2_out_valid64", ov64, 0);
    chk("rst2_immext64", imm64, 0);
    chk("rst2_in_ready32", rdy32, 1);
    out_ready = 1'b1;

    for (int i = 0; i < 400; i++) begin
      set_in($urandom, 3'($urandom_range(0, 7)), $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i < 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
